// File: rtl/io_split_align_mc.sv
// Multi-lane delay/split cell: per-lane programmable delay feeding a complementary output pair.
// Optional per-lane polarity swap enabled by defining IO_SPLIT_ALIGN_POLINV_EN.
module io_split_align_mc #(
  parameter int NCH    = 8,
  parameter int MAXDLY = 8,
  parameter int DW     = $clog2(MAXDLY)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NCH*DW-1:0] dly_sel,
`ifdef IO_SPLIT_ALIGN_POLINV_EN
  input  logic [NCH-1:0]    inv,
`endif
  input  logic [NCH-1:0]    din,
  output logic [NCH-1:0]    dout_p,
  output logic [NCH-1:0]    dout_n,
  output logic              valid
);

  localparam logic [DW-1:0] LAST = DW'(MAXDLY - 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t              state;
  logic [DW-1:0]       cnt;
  logic [MAXDLY-1:0]   sr [NCH];
  logic [NCH*DW-1:0]   dly_q;
  logic [NCH-1:0]      tap;
  logic [NCH-1:0]      run_p;
  logic                chg;

  function automatic logic [DW-1:0] clamp_sel(input logic [DW-1:0] s);
    return (int'(s) > MAXDLY - 1) ? LAST : s;
  endfunction

`ifdef IO_SPLIT_ALIGN_POLINV_EN
  logic [NCH-1:0] inv_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inv_q <= '0;
    else        inv_q <= inv;
  end

  assign chg   = (dly_sel != dly_q) || (inv != inv_q);
  assign run_p = tap ^ inv_q;
`else
  assign chg   = (dly_sel != dly_q);
  assign run_p = tap;
`endif

  // Delay lines shift unconditionally so they are already full of live data when FILL ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) sr[i] <= '0;
      dly_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) sr[i] <= {sr[i][MAXDLY-2:0], din[i]};
      dly_q <= dly_sel;
    end
  end

  always_comb begin
    tap = '0;
    for (int i = 0; i < NCH; i++) tap[i] = sr[i][clamp_sel(dly_q[i*DW +: DW])];
  end

  // Outputs are loaded from the same edge as the state change, so p/n never disagree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      valid  <= 1'b0;
      dout_p <= '0;
      dout_n <= '1;
    end else begin
      valid  <= 1'b0;
      dout_p <= '0;
      dout_n <= '1;
      case (state)
        IDLE: begin
          if (en) begin
            state <= FILL;
            cnt   <= '0;
          end
        end
        FILL: begin
          if (!en) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (chg) begin
            cnt <= '0;
          end else if (cnt == LAST) begin
            state  <= RUN;
            valid  <= 1'b1;
            dout_p <= run_p;
            dout_n <= ~run_p;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (!en) begin
            state <= IDLE;
          end else if (chg) begin
            state <= FILL;
            cnt   <= '0;
          end else begin
            valid  <= 1'b1;
            dout_p <= run_p;
            dout_n <= ~run_p;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
